// File: rtl/dsp_result_drain.sv
// dsp_result_drain: captures DSP48A1 output-stage results into a small FIFO and
// presents them downstream over valid/ready. The stall output asserts at the
// almost-full level so the slice clock enables can hold the pipeline.
// Optional macro DSP_DRAIN_OVF_EN adds a sticky overflow flag. Without it, ovf
// is tied low and overflow words are dropped silently.
module dsp_result_drain #(
  parameter int unsigned WIDTH     = 49,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AFULL_LVL = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_vld,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       stall,
  output logic                       ovf
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_pop;
  logic w_push;

  // Status comes only from the registered occupancy.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_pop    = (r_count != '0) & out_rdy;
  // When full, a write is only accepted if the head leaves in the same cycle.
  assign w_push   = in_vld & (~w_full | w_pop);

  assign out_vld  = (r_count != '0);
  assign out_data = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign full     = w_full;
  assign stall    = (r_count >= CW'(AFULL_LVL));

  // Storage write and write pointer; the pointer wraps naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
      r_wr_ptr        <= r_wr_ptr + AW'(1);
    end
  end

  // Read pointer advances on every accepted head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef DSP_DRAIN_OVF_EN
  logic r_ovf;

  // Sticky flag for a word lost while full with no pop to make room.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (in_vld & w_full & ~w_pop) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule
